rgb_fade_pwm: RTL and testbench
===============================

Name: rgb_fade_pwm

Overview:
- Output stage between the colour-pattern stage and the board RGB LED pins.
- Takes the 3-bit colour code from the pattern stage and drives the three LED pins with PWM.
- Brightness ramps up when a colour appears and ramps down before the colour is removed or changed, so colour transitions are smooth instead of hard switching.
- Fully synchronous to the system clock; the 1 Hz pattern stage feeds it directly.

Parameters:
- PWM_BITS, 8, width of the PWM counter and the brightness level; PWM period = 2^PWM_BITS cycles; MAX = 2^PWM_BITS-1.
- STEP_CYCLES, 390625, clk cycles per brightness step; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active-low.
- color_in  input  3  requested colour {R,G,B} from the pattern stage; same clock domain, level signal.
- led  output  3  PWM-modulated LED drive {R,G,B}, active-high.
- busy  output  1  high while a fade is in progress (S_UP or S_DOWN).
- level  output  PWM_BITS  current brightness register (debug/observability).

Interface (already decided): one clock; reset is synchronous and active-low. Clock port is clk, reset port is rst_n. All state updates on the rising edge of clk. rst_n is sampled only on that edge.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets the following, regardless of state, including mid-fade: state=S_OFF, level=0, color_cur=0, pwm_cnt=0, step_cnt=0, led=3'b000, busy=0.
- step_cnt: free-running 0..STEP_CYCLES-1, wraps to 0. The step tick is asserted in the cycle where step_cnt==STEP_CYCLES-1.
- pwm_cnt: free-running PWM_BITS-bit counter, wraps MAX->0.
- State machine (color_cur is the latched colour):
  - S_OFF: level=0. If color_in!=0, latch color_cur<=color_in and go to S_UP on the next edge. If color_in==0, stay.
  - S_UP: on each tick, level<=level+1. When the tick increments level to MAX, go to S_ON. If color_in!=color_cur in any cycle, go to S_DOWN immediately without changing level; the downward fade starts from the current level.
  - S_ON: level=MAX. If color_in!=color_cur, go to S_DOWN.
  - S_DOWN: on each tick, level<=level-1. When level reaches 0, go to S_OFF and clear color_cur to 0. Colour changes during S_DOWN are ignored; S_OFF picks up the new color_in one cycle later.
- level saturates: it never wraps above MAX or below 0.
- A tick and a state transition in the same cycle: the transition takes priority; level is not stepped in that cycle.
- busy = (state==S_UP) || (state==S_DOWN), registered together with the state.
- Duty: duty_eff = level. led[i] <= color_cur[i] & ((duty_eff==MAX) || (pwm_cnt < duty_eff)).
  - led is registered: one cycle of latency from pwm_cnt/level to the pin.
  - level=0 gives solid off; level=MAX gives solid on with no glitch.
- Timing: color_in 0->nonzero in cycle t gives S_UP in t+1. A full fade takes MAX ticks, i.e. between (MAX-1)*STEP_CYCLES+1 and MAX*STEP_CYCLES cycles depending on step_cnt phase.

Optional Feature:
- Macro RGB_GAMMA_EN.
- When defined, duty_eff = MAX if level==MAX, else (level*level)>>PWM_BITS. The product is computed at 2*PWM_BITS width, then the upper PWM_BITS bits are taken. This gives perceptually linear fades.
- When not defined, duty_eff = level. The state machine, level and busy are identical in both builds; only led differs.

Test Plan:
1. Reset: hold rst_n=0 for 3 clk with color_in=3'b101 -> led=000, busy=0, level=0 at every edge; release -> S_UP entered 1 cycle later, busy=1.
2. Fade-up (PWM_BITS=4, STEP_CYCLES=4): color_in 000->100 -> level steps 0..15 once per 4 cycles. level==15 at most 60 cycles after entry, then busy=0. led[2] solid 1 and led[1:0]=00 thereafter.
3. PWM duty at fixed level (PWM_BITS=4, gamma off, STEP_CYCLES large, level held at 5) -> led[2] high for exactly 5 of every 16 cycles; the other bits stay 0.
4. Colour change from S_ON: 100 -> 010 -> level ramps 15->0 on red only, then S_OFF for 1 cycle. color_cur=010, then ramps 0->15 on green; led never shows red and green together.
5. Interrupt mid-fade-up: change color_in at level=7 -> S_DOWN from 7 with no jump to 15; reaches 0 after 7 ticks; new colour then fades up.
6. Reset mid-fade at level=9 -> next edge level=0, led=000, busy=0; RGB_GAMMA_EN build at level=8, PWM_BITS=4 -> duty_eff=4, led high 4 of 16 cycles.

Source files
------------

// File: rtl/rgb_fade_pwm_if.sv
// Colour request in, PWM LED drive / fade status out, between pattern stage and pins.
// Latency: none, wires only; no backpressure, all signals are plain levels.
interface rgb_fade_pwm_if #(
    parameter int PWM_BITS = 8
);
    logic [2:0]          color_in;
    logic [2:0]          led;
    logic                busy;
    logic [PWM_BITS-1:0] level;

    modport master (output color_in, input led, input busy, input level);
    modport slave  (input color_in, output led, output busy, output level);
endinterface

// File: rtl/rgb_fade_pwm.sv
// RGB LED PWM driver: fades brightness up on a new colour, down before removing it.
// Latency: colour->S_UP 1 cycle, pwm/level->led 1 cycle; no backpressure, colour is a level input.
// Optional RGB_GAMMA_EN squares the brightness for a perceptually linear duty.
module rgb_fade_pwm #(
    parameter int PWM_BITS    = 8,
    parameter int STEP_CYCLES = 390625
) (
    input  logic          clk,
    input  logic          rst_n,
    rgb_fade_pwm_if.slave bus
);
    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PWM_BITS-1:0] MAX  = '1;
    localparam logic [STEP_W-1:0]   LAST = STEP_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {S_OFF, S_UP, S_ON, S_DOWN} state_t;

    state_t              state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic [2:0]          color_cur_q, color_cur_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [2:0]          led_q, led_d;
    logic                busy_q, busy_d;
    logic                tick;
    logic [PWM_BITS-1:0] duty_eff;

    assign tick = (step_cnt_q == LAST);

`ifdef RGB_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;
    always_comb begin
        level_sq = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
        duty_eff = (level_q == MAX) ? MAX : level_sq[2*PWM_BITS-1:PWM_BITS];
    end
`else
    always_comb begin
        duty_eff = level_q;
    end
`endif

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        color_cur_d = color_cur_q;
        pwm_cnt_d   = pwm_cnt_q + 1'b1;
        step_cnt_d  = tick ? '0 : step_cnt_q + 1'b1;

        // A colour change always wins over a pending tick: level holds that cycle.
        case (state_q)
            S_OFF: begin
                level_d = '0;
                if (bus.color_in != 3'b000) begin
                    color_cur_d = bus.color_in;
                    state_d     = S_UP;
                end
            end
            S_UP: begin
                if (bus.color_in != color_cur_q) begin
                    state_d = S_DOWN;
                end else if (tick && level_q != MAX) begin
                    level_d = level_q + 1'b1;
                    if (level_d == MAX) state_d = S_ON;
                end
            end
            S_ON: begin
                level_d = MAX;
                if (bus.color_in != color_cur_q) state_d = S_DOWN;
            end
            S_DOWN: begin
                if (level_q == '0) begin
                    state_d     = S_OFF;
                    color_cur_d = 3'b000;
                end else if (tick) begin
                    level_d = level_q - 1'b1;
                    if (level_d == '0) begin
                        state_d     = S_OFF;
                        color_cur_d = 3'b000;
                    end
                end
            end
            default: state_d = S_OFF;
        endcase

        busy_d = (state_d == S_UP) || (state_d == S_DOWN);

        for (int i = 0; i < 3; i++) begin
            led_d[i] = color_cur_q[i] & ((duty_eff == MAX) || (pwm_cnt_q < duty_eff));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            level_q     <= '0;
            color_cur_q <= 3'b000;
            pwm_cnt_q   <= '0;
            step_cnt_q  <= '0;
            led_q       <= 3'b000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            color_cur_q <= color_cur_d;
            pwm_cnt_q   <= pwm_cnt_d;
            step_cnt_q  <= step_cnt_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.led   = led_q;
    assign bus.busy  = busy_q;
    assign bus.level = level_q;
endmodule

// File: tb/tb_rgb_fade_pwm.sv
// Bench for rgb_fade_pwm: cycle scoreboard on a fast-step instance plus duty checks on a slow-step one.
module tb_rgb_fade_pwm;
    localparam int STEP_F = 4;
    localparam int STEP_S = 64;
    localparam int MAXL   = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rgb_fade_pwm_if #(.PWM_BITS(4)) if_f ();
    rgb_fade_pwm_if #(.PWM_BITS(4)) if_s ();

    rgb_fade_pwm #(.PWM_BITS(4), .STEP_CYCLES(STEP_F)) dut_f (
        .clk(clk), .rst_n(rst_n), .bus(if_f.slave));
    rgb_fade_pwm #(.PWM_BITS(4), .STEP_CYCLES(STEP_S)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(if_s.slave));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model of the fast instance, evaluated at each rising edge.
    int         m_st, m_lvl, m_cc, m_pwm, m_step;
    int         ns, nl, ncc, duty;
    bit         tk;
    logic [2:0] m_led;
    logic       m_busy;
    logic [2:0] c;
    logic [7:0] exp_q[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_st = 0; m_lvl = 0; m_cc = 0; m_pwm = 0; m_step = 0;
            m_led = 3'b000; m_busy = 1'b0;
        end else begin
            c = if_f.color_in;
`ifdef RGB_GAMMA_EN
            duty = (m_lvl == MAXL) ? MAXL : (m_lvl * m_lvl) / 16;
`else
            duty = m_lvl;
`endif
            for (int i = 0; i < 3; i++)
                m_led[i] = m_cc[i] && ((duty == MAXL) || (m_pwm < duty));
            tk = (m_step == STEP_F - 1);
            ns = m_st; nl = m_lvl; ncc = m_cc;
            case (m_st)
                0: begin
                    nl = 0;
                    if (c != 3'b000) begin ncc = int'(c); ns = 1; end
                end
                1: if (int'(c) != m_cc) ns = 3;
                   else if (tk) begin nl = m_lvl + 1; if (nl == MAXL) ns = 2; end
                2: if (int'(c) != m_cc) ns = 3;
                default: if (m_lvl == 0) begin ns = 0; ncc = 0; end
                   else if (tk) begin
                       nl = m_lvl - 1;
                       if (nl == 0) begin ns = 0; ncc = 0; end
                   end
            endcase
            m_st = ns; m_lvl = nl; m_cc = ncc;
            m_pwm  = (m_pwm + 1) % 16;
            m_step = tk ? 0 : m_step + 1;
            m_busy = (m_st == 1) || (m_st == 3);
        end
        exp_q.push_back({m_led, m_busy, 4'(m_lvl)});
    end

    logic [7:0] e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("led",   int'(if_f.led),   int'(e[7:5]));
            chk("busy",  int'(if_f.busy),  int'(e[4]));
            chk("level", int'(if_f.level), int'(e[3:0]));
            chk("one_colour", int'($countones(if_f.led) <= 1), 1);
        end
    end

    task automatic wait_level(input bit slow, input int lvl, input int budget,
                              input string tag, output int cyc);
        int l;
        cyc = 0;
        l   = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            cyc++;
            l = slow ? int'(if_s.level) : int'(if_f.level);
            if (l == lvl) return;
        end
        chk(tag, l, lvl);
    endtask

    task automatic duty_window(input string tag, input int lvl, input int exp_hi);
        int hi, other;
        hi = 0; other = 0;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            hi    += int'(if_s.led[2]);
            other += int'(if_s.led[1]) + int'(if_s.led[0]);
        end
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_gb"}, other, 0);
        chk({tag, "_lvl"}, int'(if_s.level), lvl);
    endtask

    int cyc, hi;
    localparam int EXP5 =
`ifdef RGB_GAMMA_EN
        1;
`else
        5;
`endif
    localparam int EXP8 =
`ifdef RGB_GAMMA_EN
        4;
`else
        8;
`endif

    initial begin
        rst_n = 1'b0;
        if_f.color_in = 3'b101;
        if_s.color_in = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst_busy",  int'(if_f.busy), 0);
        chk("rst_level", int'(if_f.level), 0);
        chk("rst_led",   int'(if_f.led), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_busy", int'(if_f.busy), 1);

        // Fade up on red from a clean start.
        rst_n = 1'b0;
        if_f.color_in = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        if_f.color_in = 3'b100;
        @(negedge clk);
        chk("up_busy", int'(if_f.busy), 1);
        wait_level(1'b0, 15, 80, "up_timeout", cyc);
        chk("fade_up_time", int'(cyc >= 57 && cyc <= 60), 1);
        chk("on_busy", int'(if_f.busy), 0);
        @(negedge clk);
        hi = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            hi += int'(if_f.led == 3'b100);
        end
        chk("red_solid", hi, 16);

        // Red to green through a full fade down and up.
        if_f.color_in = 3'b010;
        wait_level(1'b0, 0, 80, "rg_down_timeout", cyc);
        wait_level(1'b0, 15, 80, "rg_up_timeout", cyc);
        repeat (2) @(negedge clk);
        chk("green_on", int'(if_f.led), 3'b010);

        // Interrupt a fade-up at level 7.
        if_f.color_in = 3'b100;
        wait_level(1'b0, 0, 80, "int_down_timeout", cyc);
        wait_level(1'b0, 7, 80, "int_up_timeout", cyc);
        if_f.color_in = 3'b001;
        @(negedge clk);
        chk("int_hold_level", int'(if_f.level), 7);
        chk("int_busy", int'(if_f.busy), 1);
        wait_level(1'b0, 0, 40, "int_zero_timeout", cyc);
        chk("int_down_time", int'(cyc >= 25 && cyc <= 28), 1);
        wait_level(1'b0, 15, 80, "blue_up_timeout", cyc);
        repeat (2) @(negedge clk);
        chk("blue_on", int'(if_f.led), 3'b001);

        // Reset in the middle of a fade.
        if_f.color_in = 3'b010;
        wait_level(1'b0, 0, 80, "mid_down_timeout", cyc);
        wait_level(1'b0, 9, 80, "mid_up_timeout", cyc);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_level", int'(if_f.level), 0);
        chk("midrst_led",   int'(if_f.led), 0);
        chk("midrst_busy",  int'(if_f.busy), 0);
        if_f.color_in = 3'b000;
        rst_n = 1'b1;

        // Duty cycle at fixed levels on the slow-step instance.
        if_s.color_in = 3'b100;
        wait_level(1'b1, 5, 600, "slow5_timeout", cyc);
        duty_window("duty5", 5, EXP5);
        wait_level(1'b1, 8, 400, "slow8_timeout", cyc);
        duty_window("duty8", 8, EXP8);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
